half_mix_arbiter: RTL

//  Shares one halving mixer (out = (a>>>1) + (b>>>1)) among NREQ requesters.

---
 rtl/half_mix_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/half_mix_arbiter.sv
// half_mix_arbiter: one halving mixer, out = (a>>>1) + (b>>>1), shared by
// NREQ requesters. A round-robin search picks the next operand pair, a
// small FSM walks it through the datapath, and the result leaves with the
// winning requester's id under valid/ready flow control.
module half_mix_arbiter #(
  parameter  int DATAW           = 16,
  parameter  int NREQ            = 4,
  parameter  int REGISTER_OUTPUT = 1,
  localparam int IDW             = $clog2(NREQ)
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [NREQ-1:0]       req_valid_i,
  output logic [NREQ-1:0]       req_ready_o,
  input  logic [NREQ*DATAW-1:0] req_data1_i,
  input  logic [NREQ*DATAW-1:0] req_data2_i,
  output logic                  res_valid_o,
  input  logic                  res_ready_i,
  output logic [DATAW-1:0]      res_data_o,
  output logic [IDW-1:0]        res_id_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_OUT
  } state_t;

  state_t           r_state;
  logic [IDW-1:0]   r_ptr;
  logic [IDW-1:0]   r_id;
  logic [DATAW-1:0] r_a;
  logic [DATAW-1:0] r_b;

  logic             w_any;
  logic [IDW-1:0]   w_win;
  logic             w_can_grant;
  logic             w_grant;
  logic [DATAW-1:0] w_sum;

  // Each operand is halved with an arithmetic shift (rounds toward -inf);
  // two halves always fit in DATAW bits, so the sum cannot overflow.
  function automatic logic [DATAW-1:0] half_mix(input logic [DATAW-1:0] a,
                                                input logic [DATAW-1:0] b);
    logic signed [DATAW-1:0] ha;
    logic signed [DATAW-1:0] hb;
    ha = $signed(a) >>> 1;
    hb = $signed(b) >>> 1;
    return ha + hb;
  endfunction

  // Round-robin search: first valid requester at or above r_ptr, with wrap.
  always_comb begin
    logic [IDW-1:0] v_idx;
    // NOTE: every variable gets a default before any branch, so no path
    // leaves it unassigned and no latch is inferred.
    w_any = 1'b0;
    w_win = '0;
    v_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      v_idx = IDW'((int'(r_ptr) + i) % NREQ);
      if (!w_any && req_valid_i[v_idx]) begin
        w_any = 1'b1;
        w_win = v_idx;
      end
    end
  end

  // A grant is only possible when the datapath is empty or its result is
  // leaving this very cycle (back-to-back).
  assign w_can_grant = (r_state == S_IDLE) || ((r_state == S_OUT) && res_ready_i);
  assign w_grant     = w_can_grant && w_any;

  // Grant is combinational; it is forced low while reset is asserted so
  // every output reads 0 during reset even with requests pending.
  assign req_ready_o = (w_grant && rst_n_i) ? (NREQ'(1) << w_win) : '0;

  assign res_valid_o = (r_state == S_OUT);
  assign res_id_o    = r_id;
  assign res_data_o  = w_sum;

  // Control FSM plus operand capture on the grant edge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    // NOTE: the operand and id registers are reset along with the FSM so a
    // pair in flight is dropped and the outputs read 0 after reset.
    if (!rst_n_i) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_id    <= '0;
      r_a     <= '0;
      r_b     <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register
      // samples pre-edge values regardless of statement order.
      if (w_grant) begin
        r_a   <= req_data1_i[int'(w_win)*DATAW +: DATAW];
        r_b   <= req_data2_i[int'(w_win)*DATAW +: DATAW];
        r_id  <= w_win;
        r_ptr <= (w_win == IDW'(NREQ - 1)) ? '0 : w_win + 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_grant) r_state <= (REGISTER_OUTPUT != 0) ? S_CALC : S_OUT;
        end
        S_CALC: begin
          r_state <= S_OUT;
        end
        S_OUT: begin
          if (res_ready_i) begin
            if (w_grant) r_state <= (REGISTER_OUTPUT != 0) ? S_CALC : S_OUT;
            else         r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  generate
    if (REGISTER_OUTPUT != 0) begin : g_reg_sum
      logic [DATAW-1:0] r_sum;

      // Sum register loaded in CALC; holds through OUT even while a new
      // pair is captured back-to-back.
      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          r_sum <= '0;
        end else if (r_state == S_CALC) begin
          r_sum <= half_mix(r_a, r_b);
        end
      end

      assign w_sum = r_sum;
    end else begin : g_comb_sum
      assign w_sum = half_mix(r_a, r_b);
    end
  endgenerate

endmodule
